// File: rtl/csi2_calib_pkg.sv
// csi2_calib_pkg: shared widths and FSM state encoding for the CSI2 delay calibrator.
package csi2_calib_pkg;
   localparam int TAP_W   = 5;
   localparam int TAP_CNT = 32;
   localparam int LEN_W   = 6;
   typedef enum logic [3:0] {
      ST_IDLE, ST_APPLY, ST_SETTLE, ST_SYNC, ST_DWELL, ST_EVAL,
      ST_FINAL, ST_APPLY_FINAL, ST_LOCKED, ST_FAIL
   } calib_state_t;
endpackage

// File: rtl/csi2_eye_tracker.sv
// csi2_eye_tracker: tracks the current and widest contiguous run of good taps.
// Ports: clk_i/rst_n_i clock and async active-low reset; clr_i clears all window regs;
//   upd_i scores tap_i as good_i; best_start_o/best_len_o give the widest run seen so far.
module csi2_eye_tracker
   import csi2_calib_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             clr_i,
   input  logic             upd_i,
   input  logic [TAP_W-1:0] tap_i,
   input  logic             good_i,
   output logic [TAP_W-1:0] best_start_o,
   output logic [LEN_W-1:0] best_len_o
);
   logic [TAP_W-1:0] cur_start_q, cur_start_d, best_start_q, best_start_d;
   logic [LEN_W-1:0] cur_len_q, cur_len_d, best_len_q, best_len_d;
   logic             take_best;
   // strict compare keeps the first of equally wide windows
   always_comb begin
      cur_start_d  = clr_i ? '0 : (upd_i && good_i && cur_len_q == '0) ? tap_i : cur_start_q;
      cur_len_d    = clr_i ? '0 : !upd_i ? cur_len_q : good_i ? cur_len_q + LEN_W'(1) : '0;
      take_best    = upd_i && good_i && cur_len_d > best_len_q;
      best_start_d = clr_i ? '0 : take_best ? cur_start_d : best_start_q;
      best_len_d   = clr_i ? '0 : take_best ? cur_len_d : best_len_q;
   end
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         cur_start_q  <= '0;
         cur_len_q    <= '0;
         best_start_q <= '0;
         best_len_q   <= '0;
      end else begin
         cur_start_q  <= cur_start_d;
         cur_len_q    <= cur_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
      end
   assign best_start_o = best_start_q;
   assign best_len_o   = best_len_q;
endmodule

// File: rtl/csi2_delay_calib.sv
// csi2_delay_calib: sweeps the shared DPHY lane tap, scores each tap by CSI2 errors, loads the eye centre.
// Ports: clk_i/rst_n_i clock and async active-low reset; start_i starts/restarts calibration;
//   frame_start_i, header_err_i, crc_err_i link pulses; delay_act_o tap load strobe;
//   lane_delay_o tap per lane; busy_o/locked_o/fail_o status; eye_start_o/eye_width_o best window.
// Option: define CSI2_CALIB_AUTO_RECAL_EN to re-sweep from LOCKED when 4+ errors hit one 64-frame window.
module csi2_delay_calib
   import csi2_calib_pkg::*;
#(
   parameter int unsigned DATA_LANES     = 2,
   parameter int unsigned DWELL_FRAMES   = 4,
   parameter int unsigned SETTLE_CYCLES  = 64,
   parameter int unsigned TIMEOUT_CYCLES = 2**20,
   parameter int unsigned MIN_EYE        = 3,
   parameter int unsigned DEFAULT_TAP    = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        start_i,
   input  logic                        frame_start_i,
   input  logic                        header_err_i,
   input  logic                        crc_err_i,
   output logic                        delay_act_o,
   output logic [DATA_LANES*TAP_W-1:0] lane_delay_o,
   output logic                        busy_o,
   output logic                        locked_o,
   output logic                        fail_o,
   output logic [TAP_W-1:0]            eye_start_o,
   output logic [LEN_W-1:0]            eye_width_o
);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0]      SET_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [7:0]       DW_LAST  = 8'(DWELL_FRAMES - 1);
   localparam logic [TAP_W-1:0] DEF_TAP  = TAP_W'(DEFAULT_TAP);
   calib_state_t     state_q;
   logic [TAP_W-1:0] tap_q, lane_tap_q, eye_start_q, best_start, fin_tap;
   logic [LEN_W-1:0] eye_width_q, best_len;
   logic [15:0]      cnt_q;
   logic [TO_W-1:0]  to_q;
   logic [7:0]       frm_q;
   logic             bad_q, delay_act_q, locked_q, fail_q;
   logic             err, restart, recal, eye_ok;
   assign err     = header_err_i | crc_err_i;
   assign restart = (start_i && state_q inside {ST_IDLE, ST_LOCKED, ST_FAIL}) || recal;
   assign eye_ok  = best_len >= LEN_W'(MIN_EYE);
   assign fin_tap = TAP_W'(LEN_W'(best_start) + ((best_len - LEN_W'(1)) >> 1));
   csi2_eye_tracker u_eye (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clr_i        (restart),
      .upd_i        (state_q == ST_EVAL),
      .tap_i        (tap_q),
      .good_i       (!bad_q),
      .best_start_o (best_start),
      .best_len_o   (best_len)
   );
`ifdef CSI2_CALIB_AUTO_RECAL_EN
   logic [5:0] rc_frm_q;
   logic [2:0] rc_err_q;
   // error budget restarts with every 64th frame while locked
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         rc_frm_q <= '0;
         rc_err_q <= '0;
      end else if (state_q != ST_LOCKED || (frame_start_i && rc_frm_q == 6'd63)) begin
         rc_frm_q <= '0;
         rc_err_q <= '0;
      end else begin
         rc_frm_q <= rc_frm_q + {5'd0, frame_start_i};
         rc_err_q <= rc_err_q + {2'd0, err};
      end
   assign recal = state_q == ST_LOCKED && err && rc_err_q == 3'd3;
`else
   assign recal = 1'b0;
`endif
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         tap_q       <= '0;
         lane_tap_q  <= DEF_TAP;
         cnt_q       <= '0;
         to_q        <= '0;
         frm_q       <= '0;
         bad_q       <= 1'b0;
         delay_act_q <= 1'b0;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
         eye_start_q <= '0;
         eye_width_q <= '0;
      end else begin
         delay_act_q <= 1'b0;
         if (restart) begin
            state_q  <= ST_APPLY;
            tap_q    <= '0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
         end else
            case (state_q)
               ST_APPLY: begin
                  lane_tap_q  <= tap_q;
                  delay_act_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= ST_SETTLE;
               end
               ST_SETTLE: begin
                  cnt_q <= cnt_q + 16'd1;
                  to_q  <= '0;
                  if (cnt_q == SET_LAST) state_q <= ST_SYNC;
               end
               ST_SYNC: begin
                  to_q <= to_q + TO_W'(1);
                  frm_q <= '0;
                  bad_q <= !frame_start_i;
                  state_q <= frame_start_i ? ST_DWELL : (to_q == TO_LAST) ? ST_EVAL : ST_SYNC;
               end
               ST_DWELL: begin
                  to_q  <= to_q + TO_W'(1);
                  frm_q <= frm_q + {7'd0, frame_start_i};
                  // an error coinciding with the closing frame still belongs to this tap
                  if (err) bad_q <= 1'b1;
                  if (frame_start_i && frm_q == DW_LAST) state_q <= ST_EVAL;
                  else if (to_q == TO_LAST) begin
                     bad_q   <= 1'b1;
                     state_q <= ST_EVAL;
                  end
               end
               ST_EVAL: begin
                  tap_q   <= tap_q == TAP_W'(TAP_CNT - 1) ? tap_q : tap_q + TAP_W'(1);
                  state_q <= tap_q == TAP_W'(TAP_CNT - 1) ? ST_FINAL : ST_APPLY;
               end
               ST_FINAL: begin
                  eye_start_q <= best_start;
                  eye_width_q <= best_len;
                  tap_q       <= eye_ok ? fin_tap : DEF_TAP;
                  state_q     <= ST_APPLY_FINAL;
               end
               ST_APPLY_FINAL: begin
                  lane_tap_q  <= tap_q;
                  delay_act_q <= 1'b1;
                  locked_q    <= eye_ok;
                  fail_q      <= !eye_ok;
                  state_q     <= eye_ok ? ST_LOCKED : ST_FAIL;
               end
               default: ;
            endcase
      end
   assign delay_act_o  = delay_act_q;
   assign lane_delay_o = {DATA_LANES{lane_tap_q}};
   assign busy_o       = !(state_q inside {ST_IDLE, ST_LOCKED, ST_FAIL});
   assign locked_o     = locked_q;
   assign fail_o       = fail_q;
   assign eye_start_o  = eye_start_q;
   assign eye_width_o  = eye_width_q;
endmodule
